// File: rtl/bsn_stream_drain_pkg.sv
// Shared definitions for the bitonic-sorter output drain and its front-end loader.
package bsn_stream_drain_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Index width for an N-element vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsn_stream_drain_if.sv
// Vector-in / element-out handshake bundle of the sorter output drain.
interface bsn_stream_drain_if
  import bsn_stream_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_INPUTS   = 8
);
  localparam int unsigned IW = idx_width(N_INPUTS);

  logic [N_INPUTS*DATA_WIDTH-1:0] vec_in;
  logic                           vec_valid;
  logic                           vec_ready;
  logic                           rev;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;
  logic [IW-1:0]                  out_idx;

  modport master (
    output vec_in, vec_valid, rev, out_ready,
    input  vec_ready, out_data, out_valid, out_last, out_idx
  );

  modport slave (
    input  vec_in, vec_valid, rev, out_ready,
    output vec_ready, out_data, out_valid, out_last, out_idx
  );

endinterface

// File: rtl/bsn_elem_sel.sv
// Picks one element of the held vector, walking forward or backward by beat count.
module bsn_elem_sel #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_INPUTS   = 8,
  parameter int unsigned IW         = 3
) (
  input  logic [N_INPUTS*DATA_WIDTH-1:0] vec,
  input  logic [IW-1:0]                  cnt,
  input  logic                           rev,
  output logic [DATA_WIDTH-1:0]          data
);

  logic [DATA_WIDTH-1:0] elems [N_INPUTS];
  logic [IW-1:0]         sel;

  always_comb begin
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      elems[i] = vec[i*DATA_WIDTH +: DATA_WIDTH];
    end
    sel  = rev ? (IW'(N_INPUTS - 1) - cnt) : cnt;
    data = elems[sel];
  end

endmodule

// File: rtl/bsn_stream_drain.sv
// Serialises one sorted vector per handshake into a stream of single elements.
module bsn_stream_drain
  import bsn_stream_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_INPUTS   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  bsn_stream_drain_if.slave  bus
);

  localparam int unsigned   IW   = idx_width(N_INPUTS);
  localparam logic [IW-1:0] LAST = IW'(N_INPUTS - 1);

  state_t                         state, state_nxt;
  logic [IW-1:0]                  cnt;
  logic [N_INPUTS*DATA_WIDTH-1:0] vec_reg;
  logic                           rev_lat;
  logic                           last;
  logic                           load;
  logic                           beat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_reg <= '0;
      rev_lat <= 1'b0;
    end else if (en) begin
      state <= state_nxt;
      if (load) begin
        vec_reg <= bus.vec_in;
        rev_lat <= bus.rev;
        cnt     <= '0;
      end else if (beat && !last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // vec_ready opens during the final beat so the next vector follows without a bubble.
  always_comb begin
    last          = (state == STREAM) && (cnt == LAST);
    bus.vec_ready = en && ((state == IDLE) || (last && bus.out_ready));
    load          = bus.vec_valid && bus.vec_ready;
    beat          = en && (state == STREAM) && bus.out_ready;
    state_nxt     = state;
    case (state)
      IDLE:    if (load) state_nxt = STREAM;
      STREAM:  if (beat && last) state_nxt = load ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.out_valid = (state == STREAM);
    bus.out_last  = last;
    bus.out_idx   = cnt;
  end

  bsn_elem_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_INPUTS   (N_INPUTS),
    .IW         (IW)
  ) u_sel (
    .vec  (vec_reg),
    .cnt  (cnt),
    .rev  (rev_lat),
    .data (bus.out_data)
  );

endmodule

// File: tb/tb_bsn_stream_drain.sv
// Bench for bsn_stream_drain: directed scenarios then random traffic against a beat-queue model.
module tb_bsn_stream_drain;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  bsn_stream_drain_if #(.DATA_WIDTH(32), .N_INPUTS(8)) bus ();

  bsn_stream_drain #(.DATA_WIDTH(32), .N_INPUTS(8)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned idx;
    bit          last;
  } beat_t;

  beat_t       q[$];
  bit          fresh;
  int          total  = 0;
  int          passed = 0;
  logic [31:0] elems [8];
  bit          pat [10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask

  task automatic pack_vec();
    for (int unsigned k = 0; k < 8; k++) bus.vec_in[k*32 +: 32] = elems[k];
  endtask

  task automatic set_ramp(input int unsigned base, input int unsigned stp);
    for (int unsigned k = 0; k < 8; k++) elems[k] = 32'(base + stp * k);
    pack_vec();
  endtask

  task automatic set_rand();
    for (int unsigned k = 0; k < 8; k++) elems[k] = $urandom;
    pack_vec();
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic cycle();
    bit    ev, el, evr, ho, hv;
    beat_t h, nb;
    #1;
    ev  = (q.size() != 0);
    el  = ev && q[0].last;
    evr = en && (!ev || (el && bus.out_ready));
    chk("out_valid", bus.out_valid, ev);
    chk("vec_ready", bus.vec_ready, evr);
    chk("out_last",  bus.out_last,  el);
    if (ev) begin
      h = q[0];
      chk("out_data", bus.out_data, h.data);
      chk("out_idx",  bus.out_idx,  h.idx);
    end else if (fresh) begin
      chk("out_data_rst", bus.out_data, 0);
      chk("out_idx_rst",  bus.out_idx,  0);
    end
    ho = en && ev && bus.out_ready;
    hv = en && bus.vec_valid && evr;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      fresh = 1'b1;
    end else begin
      if (ho) void'(q.pop_front());
      if (hv) begin
        fresh = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
          nb.data = bus.rev ? elems[7-k] : elems[k];
          nb.idx  = k;
          nb.last = (k == 7);
          q.push_back(nb);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b0;
    en            = 1'b1;
    bus.vec_valid = 1'b0;
    bus.rev       = 1'b0;
    bus.out_ready = 1'b1;
    bus.vec_in    = '0;
    fresh         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b1;
    cycle();

    // Single vector, forward then reversed.
    set_ramp(10, 10);
    bus.rev = 1'b0; bus.vec_valid = 1'b1; cycle();
    bus.vec_valid = 1'b0; repeat (9) cycle();
    bus.rev = 1'b1; bus.vec_valid = 1'b1; cycle();
    bus.vec_valid = 1'b0; repeat (9) cycle();

    // Back-to-back: second vector waits until the last beat of the first.
    bus.rev = 1'b0; bus.vec_valid = 1'b1; cycle();
    set_ramp(100, 1);
    repeat (8) cycle();
    bus.vec_valid = 1'b0; repeat (10) cycle();

    // Backpressure during beat 3.
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    set_ramp(1, 3);
    bus.vec_valid = 1'b1; cycle();
    bus.vec_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = pat[i];
      cycle();
    end
    bus.out_ready = 1'b1; repeat (2) cycle();

    // Reset mid-vector, then a fresh vector.
    set_rand();
    bus.vec_valid = 1'b1; cycle();
    bus.vec_valid = 1'b0; repeat (5) cycle();
    rst = 1'b0; cycle();
    rst = 1'b1; cycle();
    set_rand();
    bus.rev = 1'b1; bus.vec_valid = 1'b1; cycle();
    bus.vec_valid = 1'b0; repeat (9) cycle();

    // Enable dropped mid-stream.
    set_rand();
    bus.rev = 1'b0; bus.vec_valid = 1'b1; cycle();
    bus.vec_valid = 1'b0; repeat (3) cycle();
    en = 1'b0; repeat (2) cycle();
    en = 1'b1; repeat (8) cycle();

    // Random traffic.
    repeat (400) begin
      en            = ($urandom_range(0, 7) != 0);
      rst           = ($urandom_range(0, 63) != 0);
      bus.vec_valid = 1'($urandom_range(0, 1));
      bus.rev       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_rand();
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
